video_timing_lp: RTL and testbench
==================================

Name: video_timing_lp

Overview:
- Parametrised video timing generator with light-pen capture, successor to the fixed 64-byte × 312/263-line timing gate array.
- Derives the byte clock enable from the 16 MHz master clock, runs H/V counters, and produces sync, active-window and blanking outputs.
- Adds armed one-shot or continuous light-pen capture at dot resolution, exposed through a 4-register CPU window with interrupt.

Parameters:
CLK_DIV, 16, master clocks per byte (H count)
HW, 6, H counter width
VW, 9, V counter width (≤16)
H_TOTAL, 64, bytes per line
H_ACT_START, 12 / H_ACT_LEN, 40, active window, bytes
H_SYNC_START, 56 / H_SYNC_LEN, 5, line sync, bytes
H_BLK_START, 54 / H_BLK_LEN, 10, line blanking, bytes
V_TOTAL0, 312 / V_TOTAL1, 263, lines per frame, mode 0 / 1
V_ACT_START0, 56 / V_ACT_START1, 31 / V_ACT_LEN, 200, active lines
V_SYNC_START0, 290 / V_SYNC_START1, 245 / V_SYNC_LEN, 3, frame sync, lines
V_BLK_LEN, 16, frame blanking lines, starting at V_SYNC_STARTx

Ports:
PIN_H16  in  1  master clock, rising edge
PIN_SYCL  in  1  asynchronous reset, active high
PIN_MODE  in  1  0 = 50 Hz set, 1 = 60 Hz set
PIN_nCKLP  in  1  light-pen pulse, asynchronous, falling edge active
PIN_CS  in  1  register window select
PIN_RW  in  1  1 = read
PIN_E  in  1  CPU bus phase; writes on its rising edge
PIN_RS  in  2  register select
D_IN  in  8  write data
D_OUT  out  8  read data
D_OE  out  1  PIN_CS & PIN_RW
PIN_SYNLT  out  1  composite sync, low = sync
PIN_nINILT  out  1  low = active window
PIN_nSUPLT  out  1  low = blank
PIN_nITLP  out  1  light-pen interrupt, low active
BYTE_EN  out  1  one-cycle pulse per byte
HCNT  out  HW  current byte
VCNT  out  VW  current line

Behaviour:
- Reset: all counters 0, mode latch 0, registered outputs high (PIN_SYNLT=1, PIN_nINILT=1, PIN_nSUPLT=1, PIN_nITLP=1), BYTE_EN=0, all latches/flags 0.
- DIV counts 0..CLK_DIV-1. BYTE_EN is asserted when DIV = CLK_DIV-1.
- On BYTE_EN, HCNT increments and wraps from H_TOTAL-1 to 0. On that wrap VCNT increments and wraps from V_TOTALm-1 to 0, where m is the mode latch.
- PIN_MODE is sampled into the mode latch only when VCNT wraps to 0. A mid-frame mode change takes effect at the next frame.
- Ranges are half-open [start, start+len). No range may wrap past the total; this is a configuration error and is not checked.
- Decode, registered with 1-cycle latency from the counter state:
  - hs = HCNT in H sync range; vs = VCNT in V sync range (mode m).
  - PIN_SYNLT = ~(hs XOR vs), which gives inverted line pulses during frame sync.
  - PIN_nINILT = 0 iff HCNT and VCNT are both in their active ranges.
  - PIN_nSUPLT = 0 iff HCNT is in H blank range OR VCNT is in [V_SYNC_STARTm, +V_BLK_LEN).
- Light pen:
  - PIN_nCKLP passes through a 2-FF synchroniser; a falling edge gives a one-cycle pulse LPE.
  - On LPE with ARM=1: latch LV=VCNT, LH=HCNT, LS=DIV[3:0], LW=~PIN_nINILT; set FLAG. No latency compensation.
  - If CONT=0, ARM clears on the same edge. LPE with ARM=0 is ignored.
- Registers, read combinational:
  - RS0: LV[7:0].
  - RS1: LV[VW-1:8], zero-padded.
  - RS2: LH, zero-padded.
  - RS3 read: {FLAG, ARM, LW, mode, LS}.
- Write (rising PIN_E edge detected internally, CS=1, RW=0), RS3 only; RS0–RS2 writes are ignored:
  - D_IN[0]=ITEN, D_IN[1]=1 sets ARM, D_IN[2]=CONT.
  - D_IN[7]=1 clears FLAG.
- PIN_nITLP = ~(FLAG & ITEN), registered.
- Simultaneous events:
  - LPE and a FLAG-clear in the same cycle: capture wins, FLAG stays 1, latches update.
  - LPE and an ARM write in the same cycle: the write is applied after the capture check, so ARM ends at 1.
- PIN_SYCL asserted mid-frame: immediate return to reset values. Counting restarts at DIV=0 on the first clock after release.

Test Plan:
- Reset release, mode 0, count 16×64 clocks → BYTE_EN pulses 64 times; HCNT wraps 63→0 and VCNT steps to 1 at clock 1024.
- Full mode-0 frame → VCNT wraps after 312 lines (319488 clocks). PIN_SYNLT is low during HCNT 56–60, and inverted on lines 290–292. PIN_nINILT is low exactly 40×200 bytes.
- PIN_MODE 0→1 at VCNT=100 → frame still 312 lines; next frame 263 lines with active start at line 31.
- Write RS3=0x03, PIN_nCKLP falls at VCNT=120, HCNT=20, DIV=5 → after 2–3 clocks RS0=120, RS2=20, RS3 = {1,0,1,0,LS=7}, i.e. LS = DIV at detect. PIN_nITLP=0; a second pulse leaves the latches unchanged.
- CONT=1 with two pulses → the second capture overwrites the latches and ARM stays 1. Writing D_IN[7]=1 in the same cycle as a capture leaves FLAG=1.
- Assert PIN_SYCL mid-line at VCNT=200 → all outputs return to reset values the same cycle; after release HCNT=0, VCNT=0, mode=0.

Source files
------------

// File: rtl/video_timing_lp.sv
// video_timing_lp: byte-rate video timing generator with light-pen capture.
// A master-clock divider produces BYTE_EN; H/V counters drive registered
// sync / active-window / blanking decodes. A light-pen falling edge can be
// captured (one-shot or continuous) into latches read through a 4-register
// CPU window, with an optional low-active interrupt.
//
// CPU window: reads are combinational whenever PIN_CS=1 and PIN_RW=1
// (D_OE marks D_OUT as valid). A write is taken on the clock after PIN_E
// rises, using PIN_CS/PIN_RW/PIN_RS/D_IN sampled on that same clock.
module video_timing_lp #(
    parameter int unsigned CLK_DIV       = 16,
    parameter int unsigned HW            = 6,
    parameter int unsigned VW            = 9,
    parameter int unsigned H_TOTAL       = 64,
    parameter int unsigned H_ACT_START   = 12,
    parameter int unsigned H_ACT_LEN     = 40,
    parameter int unsigned H_SYNC_START  = 56,
    parameter int unsigned H_SYNC_LEN    = 5,
    parameter int unsigned H_BLK_START   = 54,
    parameter int unsigned H_BLK_LEN     = 10,
    parameter int unsigned V_TOTAL0      = 312,
    parameter int unsigned V_TOTAL1      = 263,
    parameter int unsigned V_ACT_START0  = 56,
    parameter int unsigned V_ACT_START1  = 31,
    parameter int unsigned V_ACT_LEN     = 200,
    parameter int unsigned V_SYNC_START0 = 290,
    parameter int unsigned V_SYNC_START1 = 245,
    parameter int unsigned V_SYNC_LEN    = 3,
    parameter int unsigned V_BLK_LEN     = 16
) (
    input  logic          PIN_H16,
    input  logic          PIN_SYCL,
    input  logic          PIN_MODE,
    input  logic          PIN_nCKLP,
    input  logic          PIN_CS,
    input  logic          PIN_RW,
    input  logic          PIN_E,
    input  logic [1:0]    PIN_RS,
    input  logic [7:0]    D_IN,
    output logic [7:0]    D_OUT,
    output logic          D_OE,
    output logic          PIN_SYNLT,
    output logic          PIN_nINILT,
    output logic          PIN_nSUPLT,
    output logic          PIN_nITLP,
    output logic          BYTE_EN,
    output logic [HW-1:0] HCNT,
    output logic [VW-1:0] VCNT
);

    // Divider is at least 4 bits wide so the sub-byte dot position always exists.
    localparam int unsigned DW = ($clog2(CLK_DIV) > 4) ? $clog2(CLK_DIV) : 4;

    logic [DW-1:0] div;
    logic          mode;
    logic          h_last;
    logic          v_last;
    logic [31:0]   v_total;
    logic [31:0]   v_act_start;
    logic [31:0]   v_sync_start;
    logic [31:0]   h32;
    logic [31:0]   v32;
    logic          hs, vs, ha, va, hb, vb;

    // Light-pen and CPU-side state
    logic          lp_s1, lp_s2, lp_s3;
    logic          lpe;
    logic          e_q;
    logic          e_rise;
    logic          capture;
    logic          wr_ctrl;
    logic [VW-1:0] lv;
    logic [HW-1:0] lh;
    logic [3:0]    ls;
    logic          lw;
    logic          flag;
    logic          arm;
    logic          cont;
    logic          iten;
    logic          unused_bits;

    function automatic logic in_range(input logic [31:0] val,
                                      input logic [31:0] start,
                                      input logic [31:0] len);
        return (val >= start) && (val < start + len);
    endfunction

    // Mode-dependent vertical geometry
    assign v_total      = mode ? V_TOTAL1      : V_TOTAL0;
    assign v_act_start  = mode ? V_ACT_START1  : V_ACT_START0;
    assign v_sync_start = mode ? V_SYNC_START1 : V_SYNC_START0;

    assign BYTE_EN = (div == DW'(CLK_DIV - 1));
    assign h_last  = (HCNT == HW'(H_TOTAL - 1));
    assign v_last  = (32'(VCNT) == v_total - 1);

    // Divider, H/V counters and the frame-boundary mode latch
    always_ff @(posedge PIN_H16 or posedge PIN_SYCL) begin
        if (PIN_SYCL) begin
            div  <= '0;
            HCNT <= '0;
            VCNT <= '0;
            mode <= 1'b0;
        end else if (BYTE_EN) begin
            div <= '0;
            if (h_last) begin
                HCNT <= '0;
                if (v_last) begin
                    VCNT <= '0;
                    mode <= PIN_MODE;
                end else begin
                    VCNT <= VCNT + VW'(1);
                end
            end else begin
                HCNT <= HCNT + HW'(1);
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    // Range decodes from the current counter state
    assign h32 = 32'(HCNT);
    assign v32 = 32'(VCNT);
    assign hs  = in_range(h32, H_SYNC_START, H_SYNC_LEN);
    assign vs  = in_range(v32, v_sync_start, V_SYNC_LEN);
    assign ha  = in_range(h32, H_ACT_START, H_ACT_LEN);
    assign va  = in_range(v32, v_act_start, V_ACT_LEN);
    assign hb  = in_range(h32, H_BLK_START, H_BLK_LEN);
    assign vb  = in_range(v32, v_sync_start, V_BLK_LEN);

    // Registered video outputs, one clock behind the counters
    always_ff @(posedge PIN_H16 or posedge PIN_SYCL) begin
        if (PIN_SYCL) begin
            PIN_SYNLT  <= 1'b1;
            PIN_nINILT <= 1'b1;
            PIN_nSUPLT <= 1'b1;
            PIN_nITLP  <= 1'b1;
        end else begin
            PIN_SYNLT  <= ~(hs ^ vs);
            PIN_nINILT <= ~(ha & va);
            PIN_nSUPLT <= ~(hb | vb);
            PIN_nITLP  <= ~(flag & iten);
        end
    end

    // Falling edge of the synchronised pen input and rising edge of PIN_E
    assign lpe     = lp_s3 & ~lp_s2;
    assign e_rise  = PIN_E & ~e_q;
    assign capture = lpe & arm;
    assign wr_ctrl = e_rise & PIN_CS & ~PIN_RW & (PIN_RS == 2'd3);

    // Pen synchroniser, capture latches and control register; the write is
    // applied after the capture so a same-cycle ARM write survives a
    // one-shot capture, while a capture beats a same-cycle FLAG clear.
    always_ff @(posedge PIN_H16 or posedge PIN_SYCL) begin
        if (PIN_SYCL) begin
            lp_s1 <= 1'b0;
            lp_s2 <= 1'b0;
            lp_s3 <= 1'b0;
            e_q   <= 1'b0;
            lv    <= '0;
            lh    <= '0;
            ls    <= '0;
            lw    <= 1'b0;
            flag  <= 1'b0;
            arm   <= 1'b0;
            cont  <= 1'b0;
            iten  <= 1'b0;
        end else begin
            lp_s1 <= PIN_nCKLP;
            lp_s2 <= lp_s1;
            lp_s3 <= lp_s2;
            e_q   <= PIN_E;
            if (capture) begin
                lv   <= VCNT;
                lh   <= HCNT;
                ls   <= div[3:0];
                lw   <= ~PIN_nINILT;
                flag <= 1'b1;
                if (!cont) begin
                    arm <= 1'b0;
                end
            end
            if (wr_ctrl) begin
                iten <= D_IN[0];
                cont <= D_IN[2];
                if (D_IN[1]) begin
                    arm <= 1'b1;
                end
                if (D_IN[7] && !capture) begin
                    flag <= 1'b0;
                end
            end
        end
    end

    // Combinational register read mux
    always_comb begin
        D_OUT = 8'h00;
        case (PIN_RS)
            2'd0:    D_OUT = 8'(lv);
            2'd1:    D_OUT = 8'(lv >> 8);
            2'd2:    D_OUT = 8'(lh);
            default: D_OUT = {flag, arm, lw, mode, ls};
        endcase
    end

    assign D_OE        = PIN_CS & PIN_RW;
    assign unused_bits = ^D_IN[6:3];

endmodule

// File: tb/tb_video_timing_lp.sv
// tb_video_timing_lp: directed bench for video_timing_lp using a reduced
// geometry (8 clocks/byte, 16 bytes/line, 20 / 14 lines per frame) so whole
// frames fit in a short run. Expected values are hand-derived from that
// geometry and pushed into a queue; a negedge monitor pops and compares.
module tb_video_timing_lp;

  localparam int HW = 6;
  localparam int VW = 9;

  localparam int ID_RD    = 0;
  localparam int ID_HCNT  = 1;
  localparam int ID_VCNT  = 2;
  localparam int ID_BE    = 3;
  localparam int ID_SYNLT = 4;
  localparam int ID_INI   = 5;
  localparam int ID_SUP   = 6;
  localparam int ID_ITLP  = 7;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mode_pin = 1'b0;
  logic          ncklp = 1'b1;
  logic          cs = 1'b0;
  logic          rw = 1'b0;
  logic          e = 1'b0;
  logic [1:0]    rs = 2'd0;
  logic [7:0]    d_in = 8'h00;
  logic [7:0]    d_out;
  logic          d_oe;
  logic          synlt, ninilt, nsuplt, nitlp, byte_en;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  video_timing_lp #(
    .CLK_DIV(8), .HW(HW), .VW(VW), .H_TOTAL(16),
    .H_ACT_START(3), .H_ACT_LEN(10),
    .H_SYNC_START(14), .H_SYNC_LEN(2),
    .H_BLK_START(13), .H_BLK_LEN(3),
    .V_TOTAL0(20), .V_TOTAL1(14),
    .V_ACT_START0(4), .V_ACT_START1(2), .V_ACT_LEN(10),
    .V_SYNC_START0(16), .V_SYNC_START1(12), .V_SYNC_LEN(1),
    .V_BLK_LEN(2)
  ) dut (
    .PIN_H16(clk), .PIN_SYCL(rst), .PIN_MODE(mode_pin), .PIN_nCKLP(ncklp),
    .PIN_CS(cs), .PIN_RW(rw), .PIN_E(e), .PIN_RS(rs), .D_IN(d_in),
    .D_OUT(d_out), .D_OE(d_oe), .PIN_SYNLT(synlt), .PIN_nINILT(ninilt),
    .PIN_nSUPLT(nsuplt), .PIN_nITLP(nitlp), .BYTE_EN(byte_en),
    .HCNT(hcnt), .VCNT(vcnt)
  );

  // clocks since reset release
  int ncyc = 0;
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int be_cnt = 0;
  int sync_lo = 0;
  int act_lo = 0;
  int blk_lo = 0;

  logic [15:0] exp_q[$];
  int          id_q[$];

  function automatic string id_name(int id);
    case (id)
      ID_RD:    return "d_out";
      ID_HCNT:  return "hcnt";
      ID_VCNT:  return "vcnt";
      ID_BE:    return "byte_en";
      ID_SYNLT: return "synlt";
      ID_INI:   return "ninilt";
      ID_SUP:   return "nsuplt";
      default:  return "nitlp";
    endcase
  endfunction

  function automatic logic [15:0] actual(int id);
    case (id)
      ID_RD:    return 16'(d_out);
      ID_HCNT:  return 16'(hcnt);
      ID_VCNT:  return 16'(vcnt);
      ID_BE:    return 16'(byte_en);
      ID_SYNLT: return 16'(synlt);
      ID_INI:   return 16'(ninilt);
      ID_SUP:   return 16'(nsuplt);
      default:  return 16'(nitlp);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at ncyc=%0d: actual=%0d expected=%0d", name, ncyc, act, exp);
    end
  endtask

  // scoreboard monitor: probes are compared on the next negedge, reads when D_OE is up
  always @(negedge clk) begin
    int id;
    logic [15:0] ex;
    while (id_q.size() > 0 && (id_q[0] != ID_RD || d_oe)) begin
      id = id_q.pop_front();
      ex = exp_q.pop_front();
      check(id_name(id), int'(actual(id)), int'(ex));
    end
  end

  // aggregate counters over the first mode-0 frame
  always @(negedge clk) begin
    if (phase == 1 && !rst) begin
      if (ncyc < 128 && byte_en) be_cnt++;
      if (ncyc >= 1 && ncyc <= 2560) begin
        if (!synlt)  sync_lo++;
        if (!ninilt) act_lo++;
        if (!nsuplt) blk_lo++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // driver tasks
  task automatic at(int n);
    while (ncyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(int id, logic [15:0] v);
    id_q.push_back(id);
    exp_q.push_back(v);
  endtask

  task automatic rd(logic [1:0] r, logic [7:0] v);
    cs = 1'b1;
    rw = 1'b1;
    rs = r;
    probe(ID_RD, 16'(v));
    @(posedge clk);
    #1;
    cs = 1'b0;
    rw = 1'b0;
  endtask

  task automatic wr(logic [1:0] r, logic [7:0] v);
    cs = 1'b1;
    rw = 1'b0;
    rs = r;
    d_in = v;
    e = 1'b1;
    @(posedge clk);
    #1;
    e = 1'b0;
    cs = 1'b0;
  endtask

  task automatic probe_reset_values();
    probe(ID_HCNT, 0);
    probe(ID_VCNT, 0);
    probe(ID_BE, 0);
    probe(ID_SYNLT, 1);
    probe(ID_INI, 1);
    probe(ID_SUP, 1);
    probe(ID_ITLP, 1);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    probe_reset_values();
    rd(2'd0, 8'h00);
    rd(2'd3, 8'h00);
    rst = 1'b0;
    phase = 1;

    // first line: decode spot checks and byte/line wrap
    at(105);  probe(ID_SUP, 0);
    at(112);  probe(ID_SYNLT, 1);
    at(113);  probe(ID_SYNLT, 0);
    at(127);  probe(ID_HCNT, 15); probe(ID_VCNT, 0); probe(ID_BE, 1);
    at(128);  probe(ID_HCNT, 0);  probe(ID_VCNT, 1); probe(ID_BE, 0);
    // frame blanking and inverted line pulses during frame sync
    at(1961); probe(ID_SUP, 1);
    at(2057); probe(ID_SUP, 0);
    at(2089); probe(ID_SYNLT, 0);
    at(2161); probe(ID_SYNLT, 1);
    at(2559); probe(ID_VCNT, 19); probe(ID_HCNT, 15);
    at(2560); probe(ID_VCNT, 0);  probe(ID_HCNT, 0);
    at(2600);
    check("byte_en_pulses", be_cnt, 16);
    check("sync_low_clocks", sync_lo, 416);
    check("active_clocks", act_lo, 800);
    check("blank_clocks", blk_lo, 688);

    // mid-frame mode change only takes effect at the next frame
    at(3200); mode_pin = 1'b1;
    at(4992); probe(ID_VCNT, 19);
    at(5119); probe(ID_VCNT, 19);
    at(5120); probe(ID_VCNT, 0);
    at(5121); rd(2'd3, 8'h10);
    at(5289); probe(ID_INI, 1);
    at(5417); probe(ID_INI, 0);
    at(6911); probe(ID_VCNT, 13);
    at(6912); probe(ID_VCNT, 0);

    // reset asserted mid-frame in the active window
    at(8234); probe(ID_INI, 0);
    at(8235);
    rst = 1'b1;
    mode_pin = 1'b0;
    probe_reset_values();
    rd(2'd3, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    phase = 2;
    probe(ID_HCNT, 0);
    probe(ID_VCNT, 0);
    at(1);    probe(ID_HCNT, 0);

    // control write; window writes to RS0 are ignored
    at(10);   wr(2'd0, 8'hFF);
    at(20);   wr(2'd3, 8'h03);
    at(30);   probe(ID_ITLP, 1); rd(2'd0, 8'h00); rd(2'd3, 8'h40);

    // one-shot capture at line 5, byte 5, dot 5 -> LS=7
    at(685);  ncklp = 1'b0;
    at(690);  ncklp = 1'b1; probe(ID_ITLP, 0);
    at(700);  rd(2'd0, 8'h05); rd(2'd1, 8'h00); rd(2'd2, 8'h05); rd(2'd3, 8'hA7);
    // second pulse with ARM cleared is ignored
    at(970);  ncklp = 1'b0;
    at(980);  ncklp = 1'b1;
    at(1000); rd(2'd0, 8'h05); rd(2'd2, 8'h05); rd(2'd3, 8'hA7);
    // clear FLAG, interrupt disabled
    at(1010); wr(2'd3, 8'h80); rd(2'd3, 8'h27);
    at(1015); probe(ID_ITLP, 1);

    // continuous mode: two captures, ARM stays set
    at(1020); wr(2'd3, 8'h07);
    at(1107); ncklp = 1'b0;
    at(1120); ncklp = 1'b1; probe(ID_ITLP, 0);
    rd(2'd0, 8'h08); rd(2'd2, 8'h0A); rd(2'd3, 8'hE5);
    at(1264); ncklp = 1'b0;
    at(1275); ncklp = 1'b1;
    rd(2'd0, 8'h09); rd(2'd2, 8'h0E); rd(2'd3, 8'hC2);

    // one-shot capture coinciding with a FLAG-clear + ARM-set write
    at(1285); wr(2'd3, 8'h03);
    at(1297); ncklp = 1'b0;
    at(1299); wr(2'd3, 8'h82);
    at(1305); ncklp = 1'b1;
    at(1310); probe(ID_ITLP, 1);
    rd(2'd0, 8'h0A); rd(2'd2, 8'h02); rd(2'd3, 8'hC3);

    // final report
    at(1320);
    check("pending_expectations", id_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
